note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/song_pkg.sv | 29 ++
 rtl/seq_timer.sv | 29 ++
 rtl/note_sequencer.sv | 158 +++++++++++++++
 tb/tb_note_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared song-entry layout, sequencer state encoding and entry field helpers.
package song_pkg;

    localparam int NOTE_W  = 7;
    localparam int DUR_W   = 5;
    localparam int ENTRY_W = 12;
    localparam int TIMER_W = 32;

    localparam logic [NOTE_W-1:0]  NOTE_REST  = '0;
    localparam logic [ENTRY_W-1:0] END_MARKER = 12'h000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } seq_state_e;

    function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that holds at zero; load wins over count enable.
module seq_timer
    import song_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/note_sequencer.sv
// Song ROM player driving a buzzer note code, with free-play passthrough when idle.
//
// state | meaning
// IDLE  | note follows key_note, waiting for start
// FETCH | rom_addr presented to the ROM, note silent
// LOAD  | entry sampled: end marker, play or skip to gap
// PLAY  | latched note sounds for dur*UNIT_CYCLES unpaused cycles
// GAP   | silent articulation gap, then next entry or DONE
// DONE  | one-cycle done pulse
module note_sequencer
    import song_pkg::*;
#(
    parameter int  UNIT_CYCLES = 12_500_000,
    parameter int  GAP_CYCLES  = 1_000_000,
    parameter int  SONG_DEPTH  = 64,
    localparam int ADDR_W      = $clog2(SONG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [NOTE_W-1:0]  key_note,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic [NOTE_W-1:0]  note,
    output logic               busy,
    output logic               done
);

    localparam logic [TIMER_W-1:0] UNIT_U    = TIMER_W'(UNIT_CYCLES);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_DEPTH - 1);

    seq_state_e         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [NOTE_W-1:0]  r_note;
    logic [NOTE_W-1:0]  r_code;

    seq_state_e         w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [NOTE_W-1:0]  w_note_nxt;
    logic [NOTE_W-1:0]  w_code_nxt;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_val;
    logic               w_tmr_en;
    logic               w_tmr_zero;
    logic [NOTE_W-1:0]  w_entry_note;
    logic [DUR_W-1:0]   w_entry_dur;
    logic [TIMER_W-1:0] w_play_cycles;

    assign w_entry_note  = entry_note(rom_data);
    assign w_entry_dur   = entry_dur(rom_data);
    // Full 32-bit product: 31 * 12.5M still fits without truncation.
    assign w_play_cycles = {{(TIMER_W-DUR_W){1'b0}}, w_entry_dur} * UNIT_U;

    seq_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_note_nxt  = NOTE_REST;
        w_code_nxt  = r_code;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_en    = ((r_state == S_PLAY) || (r_state == S_GAP)) && !pause;

        if (stop && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
            w_code_nxt  = NOTE_REST;
            w_tmr_load  = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = '0;
                    end else begin
                        w_note_nxt = key_note;
                    end
                end
                S_FETCH: begin
                    w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (rom_data == END_MARKER) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_code_nxt = w_entry_note;
                        w_tmr_load = 1'b1;
                        if (w_entry_dur == '0) begin
                            w_state_nxt = S_GAP;
                            w_tmr_val   = GAP_LOAD;
                        end else begin
                            // Counter runs N-1..0 so the zero flag marks the last PLAY cycle.
                            w_state_nxt = S_PLAY;
                            w_tmr_val   = w_play_cycles - 1'b1;
                            w_note_nxt  = w_entry_note;
                        end
                    end
                end
                S_PLAY: begin
                    if (!pause && w_tmr_zero) begin
                        w_state_nxt = S_GAP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = GAP_LOAD;
                    end else if (!pause) begin
                        w_note_nxt = r_code;
                    end
                end
                S_GAP: begin
                    if (!pause && w_tmr_zero) begin
                        if (r_addr == LAST_ADDR) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_FETCH;
                            w_addr_nxt  = r_addr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_note  <= NOTE_REST;
            r_code  <= NOTE_REST;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_note  <= w_note_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign rom_addr = r_addr;
    assign note     = r_note;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench: per-cycle vector table plus cycle traces for multi-cycle corner cases.
module tb_note_sequencer;

    localparam int UNIT  = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [6:0]  key_note = '0;
    logic [2:0]  rom_addr;
    logic [11:0] rom_data;
    logic [6:0]  note;
    logic        busy;
    logic        done;

    logic [11:0] rom [DEPTH];

    note_sequencer #(
        .UNIT_CYCLES (UNIT),
        .GAP_CYCLES  (GAP),
        .SONG_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .key_note (key_note),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        int start, stop, pause, key;
        int e_note, e_busy, e_done, e_addr;
    } vec_t;

    vec_t vt[20];
    int   n_chk = 0;
    int   n_fail = 0;
    int   tr_note[64], tr_addr[64], tr_done[64], tr_busy[64];
    int   e_note[$], e_addr[$], e_done[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ent(input int n, input int d);
        logic [6:0] nn;
        logic [4:0] dd;
        nn = n[6:0];
        dd = d[4:0];
        return {nn, dd};
    endfunction

    function automatic vec_t mk(input int s, input int st, input int p, input int k,
                                input int en, input int eb, input int ed, input int ea);
        vec_t v;
        v.start = s; v.stop = st; v.pause = p; v.key = k;
        v.e_note = en; v.e_busy = eb; v.e_done = ed; v.e_addr = ea;
        return v;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    endtask

    task automatic clear_exp();
        e_note.delete();
        e_addr.delete();
        e_done.delete();
    endtask

    task automatic push(input int nv, input int av, input int dv, input int len);
        for (int i = 0; i < len; i++) begin
            e_note.push_back(nv);
            e_addr.push_back(av);
            e_done.push_back(dv);
        end
    endtask

    // Expected per-cycle trace from ROM contents, starting the cycle after start.
    task automatic build_song();
        logic [11:0] e;
        int dur;
        clear_exp();
        for (int a = 0; a < DEPTH; a++) begin
            push(0, a, 0, 2);
            e = rom[a];
            if (e == 12'h000) begin
                push(0, a, 1, 1);
                push(0, a, 0, 1);
                return;
            end
            dur = int'(e[4:0]);
            if (dur > 0) push(int'(e[11:5]), a, 0, dur * UNIT);
            push(0, a, 0, GAP);
            if (a == DEPTH - 1) begin
                push(0, a, 1, 1);
                push(0, a, 0, 1);
            end
        end
    endtask

    // Pulse start, then record n samples; pause high over cycles plo..phi, stop at cycle stop_at.
    task automatic run_song(input int n, input int plo, input int phi, input int stop_at);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < n; j++) begin
            tr_note[j] = int'(note);
            tr_addr[j] = int'(rom_addr);
            tr_done[j] = int'(done);
            tr_busy[j] = int'(busy);
            pause = (j >= plo) && (j <= phi);
            stop  = (j == stop_at);
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic cmp_trace(input string tag);
        for (int i = 0; i < e_note.size(); i++) begin
            chk($sformatf("%s note[%0d]", tag, i), tr_note[i], e_note[i]);
            chk($sformatf("%s addr[%0d]", tag, i), tr_addr[i], e_addr[i]);
            chk($sformatf("%s done[%0d]", tag, i), tr_done[i], e_done[i]);
        end
    endtask

    task automatic abort_song();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int hi;

        // start stop pause key | note busy done addr
        vt[0]  = mk(0, 0, 0, 3,   3, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 21, 21, 0, 0, 0);
        vt[2]  = mk(1, 1, 0, 7,   7, 0, 0, 0);
        vt[3]  = mk(1, 0, 0, 9,   0, 1, 0, 0);
        vt[4]  = mk(0, 0, 0, 9,   0, 1, 0, 0);
        for (int i = 5; i <= 12; i++) vt[i] = mk(0, 0, 0, 9, 8, 1, 0, 0);
        vt[7]  = mk(1, 0, 0, 9,   8, 1, 0, 0);
        vt[13] = mk(0, 0, 0, 9,   0, 1, 0, 0);
        vt[14] = mk(0, 0, 0, 9,   0, 1, 0, 0);
        vt[15] = mk(0, 0, 0, 9,   0, 1, 0, 1);
        vt[16] = mk(0, 0, 0, 9,   0, 1, 0, 1);
        vt[17] = mk(0, 0, 0, 9,   0, 1, 1, 1);
        vt[18] = mk(0, 0, 0, 9,   0, 0, 0, 1);
        vt[19] = mk(0, 0, 0, 9,   9, 0, 0, 1);

        clear_rom();
        rom[0] = ent(8, 2);

        #12;
        chk("reset note", int'(note), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset addr", int'(rom_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start    = (vt[i].start != 0);
            stop     = (vt[i].stop != 0);
            pause    = (vt[i].pause != 0);
            key_note = 7'(vt[i].key);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d note", i), int'(note), vt[i].e_note);
            chk($sformatf("vec%0d busy", i), int'(busy), vt[i].e_busy);
            chk($sformatf("vec%0d done", i), int'(done), vt[i].e_done);
            chk($sformatf("vec%0d addr", i), int'(rom_addr), vt[i].e_addr);
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; pause = 1'b0; key_note = '0;
        @(negedge clk);

        // Two identical notes must be separated by silence.
        clear_rom();
        rom[0] = ent(12, 1);
        rom[1] = ent(12, 1);
        build_song();
        run_song(e_note.size(), -1, -1, -1);
        cmp_trace("rearticulate");

        // Pause for 5 cycles inside an 8-cycle note.
        clear_rom();
        rom[0] = ent(8, 2);
        clear_exp();
        push(0, 0, 0, 2);
        push(8, 0, 0, 3);
        push(0, 0, 0, 5);
        push(8, 0, 0, 5);
        push(0, 0, 0, GAP);
        push(0, 1, 0, 2);
        push(0, 1, 1, 1);
        push(0, 1, 0, 1);
        run_song(e_note.size(), 4, 8, -1);
        cmp_trace("pause");
        hi = 0;
        for (int j = 0; j < e_note.size(); j++) if (tr_note[j] == 8) hi++;
        chk("pause total high cycles", hi, 8);

        // Stop while entry 1 plays, then replay from entry 0.
        clear_rom();
        rom[0] = ent(8, 1);
        rom[1] = ent(10, 2);
        clear_exp();
        push(0, 0, 0, 2);
        push(8, 0, 0, 4);
        push(0, 0, 0, GAP);
        push(0, 1, 0, 2);
        push(10, 1, 0, 3);
        push(0, 0, 0, 3);
        run_song(e_note.size(), -1, -1, 12);
        cmp_trace("stop");
        chk("stop busy before", tr_busy[12], 1);
        chk("stop busy after", tr_busy[13], 0);
        clear_exp();
        push(0, 0, 0, 2);
        push(8, 0, 0, 4);
        run_song(e_note.size(), -1, -1, -1);
        cmp_trace("replay");
        abort_song();

        // Full ROM without end marker: note >21, rest, and zero-duration entries.
        clear_rom();
        rom[0] = ent(25, 1);
        rom[1] = ent(0, 1);
        for (int i = 2; i < DEPTH; i++) rom[i] = ent(3, 0);
        build_song();
        run_song(e_note.size(), -1, -1, -1);
        cmp_trace("fullrom");
        chk("fullrom final addr", int'(rom_addr), DEPTH - 1);
        chk("fullrom final busy", int'(busy), 0);

        // Asynchronous reset in the middle of entry 1's gap.
        clear_rom();
        rom[0] = ent(8, 1);
        rom[1] = ent(9, 1);
        run_song(15, -1, -1, -1);
        chk("gap pre-reset busy", int'(busy), 1);
        chk("gap pre-reset addr", int'(rom_addr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset busy", int'(busy), 0);
        chk("async reset addr", int'(rom_addr), 0);
        chk("async reset note", int'(note), 0);
        chk("async reset done", int'(done), 0);
        key_note = 7'd5;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset key note", int'(note), 5);
        key_note = '0;
        clear_exp();
        push(0, 0, 0, 2);
        push(8, 0, 0, 4);
        run_song(e_note.size(), -1, -1, -1);
        cmp_trace("post-reset replay");
        abort_song();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
